// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, all-bank address and
// engine state type, used by both the read and write engines.
package sdram_pkg;

  // {CKE, CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [4:0] CMD_NOP   = 5'b10111;
  localparam logic [4:0] CMD_PREC  = 5'b10010;
  localparam logic [4:0] CMD_ACT   = 5'b10011;
  localparam logic [4:0] CMD_WRITE = 5'b10100;
  localparam logic [4:0] CMD_READ  = 5'b10101;

  localparam logic [11:0] ADDR_PALL = 12'h400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREC,
    ST_ACT,
    ST_WR,
    ST_TWR,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sdram_step_cnt.sv
// Loadable down-counter with terminal-count flag; times the phases of the
// SDRAM engines. Holds at zero until reloaded.
module sdram_step_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/sdram_write.sv
// Write-burst engine: PRECHARGE all, ACTIVE row, one WRITE burst fed from the
// write FIFO, write recovery, one-cycle ack. Optional byte masks: SDRAM_WR_DQM_EN.
module sdram_write
  import sdram_pkg::*;
#(
  parameter int unsigned TRP_CYC   = 2,
  parameter int unsigned TRCD_CYC  = 2,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TWR_CYC   = 2
) (
  input  logic        S_CLK,
  input  logic        RST,
  input  logic        write_en,
  output logic        write_ack,
  input  logic [19:0] sdram_addr,
  output logic        fifo_rd_req,
  input  logic [15:0] fifo_rd_data,
`ifdef SDRAM_WR_DQM_EN
  input  logic [1:0]  fifo_rd_mask,
  output logic [1:0]  write_dqm,
`endif
  output logic [11:0] write_addr,
  output logic [4:0]  write_cmd,
  output logic [15:0] write_dq,
  output logic        write_dq_oe
);

  localparam int unsigned MAX_AB  = (TRP_CYC > TRCD_CYC) ? TRP_CYC : TRCD_CYC;
  localparam int unsigned MAX_CD  = (BURST_LEN > TWR_CYC) ? BURST_LEN : TWR_CYC;
  localparam int unsigned MAX_LEN = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW      = $clog2(MAX_LEN) + 1;
`ifdef SDRAM_WR_DQM_EN
  localparam int unsigned WORD_W  = 18;
`else
  localparam int unsigned WORD_W  = 16;
`endif

  state_t          state, state_n;
  logic [11:0]     row;
  logic [7:0]      col;
  logic            latch;
  logic [4:0]      cmd_n;
  logic [11:0]     addr_n;
  logic            ack_n, req_n, oe_n;
  logic            ph_load, ph_tc, rq_load, rq_tc;
  logic [CW-1:0]   ph_val;
  logic [WORD_W-1:0] fifo_word, word_src;

`ifdef SDRAM_WR_DQM_EN
  assign fifo_word = {fifo_rd_mask, fifo_rd_data};
`else
  assign fifo_word = fifo_rd_data;
`endif

  sdram_step_cnt #(.W(CW)) u_phase (
    .clk(S_CLK), .rst(RST), .load(ph_load), .load_val(ph_val), .tc(ph_tc)
  );

  sdram_step_cnt #(.W(CW)) u_req (
    .clk(S_CLK), .rst(RST), .load(rq_load), .load_val(CW'(BURST_LEN - 1)), .tc(rq_tc)
  );

  // Requests start in the first ACT cycle; extra TRCD_CYC-2 stages keep word 0
  // aligned with the WRITE command for any row-to-column delay.
  if (TRCD_CYC > 2) begin : g_dly
    logic [WORD_W-1:0] dly [TRCD_CYC-2];
    always_ff @(posedge S_CLK) begin
      if (RST) begin
        for (int unsigned i = 0; i < TRCD_CYC - 2; i++) dly[i] <= '0;
      end else begin
        dly[0] <= fifo_word;
        for (int unsigned i = 1; i < TRCD_CYC - 2; i++) dly[i] <= dly[i-1];
      end
    end
    assign word_src = dly[TRCD_CYC-3];
  end else begin : g_nodly
    assign word_src = fifo_word;
  end

  always_comb begin
    state_n = state;
    latch   = 1'b0;
    ph_load = 1'b0;
    ph_val  = '0;
    rq_load = 1'b0;
    cmd_n   = CMD_NOP;
    addr_n  = write_addr;
    ack_n   = 1'b0;
    req_n   = fifo_rd_req;
    unique case (state)
      ST_IDLE: if (write_en) begin
        state_n = ST_PREC;
        latch   = 1'b1;
        ph_load = 1'b1;
        ph_val  = CW'(TRP_CYC - 1);
        cmd_n   = CMD_PREC;
        addr_n  = ADDR_PALL;
      end
      ST_PREC: if (ph_tc) begin
        state_n = ST_ACT;
        ph_load = 1'b1;
        ph_val  = CW'(TRCD_CYC - 1);
        cmd_n   = CMD_ACT;
        addr_n  = row;
      end
      ST_ACT: if (ph_tc) begin
        state_n = ST_WR;
        ph_load = 1'b1;
        ph_val  = CW'(BURST_LEN - 1);
        cmd_n   = CMD_WRITE;
        addr_n  = {4'b0000, col};
      end
      ST_WR: if (ph_tc) begin
        state_n = ST_TWR;
        ph_load = 1'b1;
        ph_val  = CW'(TWR_CYC - 1);
      end
      ST_TWR: if (ph_tc) begin
        state_n = ST_DONE;
        ack_n   = 1'b1;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        addr_n  = ADDR_PALL;
      end
      default: state_n = ST_IDLE;
    endcase
    if (state == ST_PREC && ph_tc) begin
      req_n   = 1'b1;
      rq_load = 1'b1;
    end else if (fifo_rd_req && rq_tc) begin
      req_n   = 1'b0;
    end
    oe_n = (state_n == ST_WR);
  end

  always_ff @(posedge S_CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      row         <= '0;
      col         <= '0;
      write_cmd   <= CMD_NOP;
      write_addr  <= ADDR_PALL;
      write_dq    <= '0;
      write_dq_oe <= 1'b0;
      fifo_rd_req <= 1'b0;
      write_ack   <= 1'b0;
`ifdef SDRAM_WR_DQM_EN
      write_dqm   <= 2'b00;
`endif
    end else begin
      state       <= state_n;
      if (latch) {row, col} <= sdram_addr;
      write_cmd   <= cmd_n;
      write_addr  <= addr_n;
      write_dq    <= oe_n ? word_src[15:0] : '0;
      write_dq_oe <= oe_n;
      fifo_rd_req <= req_n;
      write_ack   <= ack_n;
`ifdef SDRAM_WR_DQM_EN
      write_dqm   <= oe_n ? word_src[17:16] : 2'b00;
`endif
    end
  end

endmodule

// File: tb/tb_sdram_write.sv
// Directed bench for sdram_write: default-parameter instance plus a
// TRP=3/TRCD=3/BURST=8/TWR=1 instance, each fed by a 1-cycle-latency FIFO model.
module tb_sdram_write;

  logic        clk = 1'b0;
  logic        rst;
  int          total = 0;
  int          bad   = 0;

  logic        we_a, ack_a, req_a, oe_a;
  logic [19:0] sa_a;
  logic [15:0] rd_a, dq_a;
  logic [11:0] addr_a;
  logic [4:0]  cmd_a;
  logic [1:0]  dqm_a;
  int          ptr_a = 0;

  logic        we_b, ack_b, req_b, oe_b;
  logic [19:0] sa_b;
  logic [15:0] rd_b, dq_b;
  logic [11:0] addr_b;
  logic [4:0]  cmd_b;
  logic [1:0]  dqm_b;
  int          ptr_b = 0;

`ifdef SDRAM_WR_DQM_EN
  logic [1:0]  mask_a, mask_b;
`else
  assign dqm_a = 2'b00;
  assign dqm_b = 2'b00;
`endif

  always #5 clk = ~clk;

  sdram_write u_a (
    .S_CLK(clk), .RST(rst), .write_en(we_a), .write_ack(ack_a), .sdram_addr(sa_a),
    .fifo_rd_req(req_a), .fifo_rd_data(rd_a),
`ifdef SDRAM_WR_DQM_EN
    .fifo_rd_mask(mask_a), .write_dqm(dqm_a),
`endif
    .write_addr(addr_a), .write_cmd(cmd_a), .write_dq(dq_a), .write_dq_oe(oe_a)
  );

  sdram_write #(.TRP_CYC(3), .TRCD_CYC(3), .BURST_LEN(8), .TWR_CYC(1)) u_b (
    .S_CLK(clk), .RST(rst), .write_en(we_b), .write_ack(ack_b), .sdram_addr(sa_b),
    .fifo_rd_req(req_b), .fifo_rd_data(rd_b),
`ifdef SDRAM_WR_DQM_EN
    .fifo_rd_mask(mask_b), .write_dqm(dqm_b),
`endif
    .write_addr(addr_b), .write_cmd(cmd_b), .write_dq(dq_b), .write_dq_oe(oe_b)
  );

  function automatic logic [15:0] word_of(input int i);
    return (i < 4) ? 16'(16'h1111 * (i + 1)) : 16'(16'hA000 + i);
  endfunction

  // FIFO models: the word appears the cycle after the request edge
  always @(posedge clk) begin
    if (req_a) begin
      rd_a  <= word_of(ptr_a);
`ifdef SDRAM_WR_DQM_EN
      mask_a <= 2'(ptr_a);
`endif
      ptr_a <= ptr_a + 1;
    end
    if (req_b) begin
      rd_b  <= word_of(ptr_b);
`ifdef SDRAM_WR_DQM_EN
      mask_b <= 2'(ptr_b);
`endif
      ptr_b <= ptr_b + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string who, input int c,
                             input int trp, input int trcd, input int bl, input int twr,
                             input int base, input logic [11:0] row, input logic [7:0] col,
                             input logic [4:0] cmd, input logic [11:0] addr,
                             input logic [15:0] dq, input logic oe, input logic req,
                             input logic ack, input logic [1:0] dqm);
    int          wr0;
    logic [4:0]  ecmd;
    logic        eoe;
    wr0  = trp + trcd;
    ecmd = (c == 0) ? 5'b10010 : (c == trp) ? 5'b10011 : (c == wr0) ? 5'b10100 : 5'b10111;
    eoe  = (c >= wr0) && (c < wr0 + bl);
    chk($sformatf("%s c%0d cmd", who, c), 32'(cmd), 32'(ecmd));
    if (c == 0)   chk($sformatf("%s c%0d addr_pall", who, c), 32'(addr), 32'h400);
    if (c == trp) chk($sformatf("%s c%0d addr_row", who, c), 32'(addr), 32'(row));
    if (c == wr0) chk($sformatf("%s c%0d addr_col", who, c), 32'(addr), 32'({4'b0000, col}));
    chk($sformatf("%s c%0d oe", who, c), 32'(oe), 32'(eoe));
    if (eoe) chk($sformatf("%s c%0d dq", who, c), 32'(dq), 32'(word_of(base + c - wr0)));
    chk($sformatf("%s c%0d req", who, c), 32'(req), 32'((c >= trp) && (c < trp + bl)));
    chk($sformatf("%s c%0d ack", who, c), 32'(ack), 32'(c == wr0 + bl + twr));
`ifdef SDRAM_WR_DQM_EN
    chk($sformatf("%s c%0d dqm", who, c), 32'(dqm),
        eoe ? 32'(2'(base + c - wr0)) : 32'h0);
`else
    if (dqm !== 2'b00) chk($sformatf("%s c%0d dqm_tie", who, c), 32'(dqm), 32'h0);
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    we_a = 1'b0; sa_a = '0;
    we_b = 1'b0; sa_b = '0;
    repeat (3) tick();

    // reset state
    chk("rst cmd_a",  32'(cmd_a),  32'h17);
    chk("rst addr_a", 32'(addr_a), 32'h400);
    chk("rst dq_a",   32'(dq_a),   32'h0);
    chk("rst oe_a",   32'(oe_a),   32'h0);
    chk("rst req_a",  32'(req_a),  32'h0);
    chk("rst ack_a",  32'(ack_a),  32'h0);
    chk("rst dqm_a",  32'(dqm_a),  32'h0);
    chk("rst cmd_b",  32'(cmd_b),  32'h17);
    chk("rst addr_b", 32'(addr_b), 32'h400);
    rst = 1'b0;
    tick();

    // burst 1, write_en held through ack so burst 2 starts at the earliest edge
    sa_a = 20'hABC12;
    we_a = 1'b1;
    tick();
    for (int c = 0; c <= 11; c++) begin
      check_cycle("b1", c, 2, 2, 4, 2, 0, 12'hABC, 8'h12,
                  cmd_a, addr_a, dq_a, oe_a, req_a, ack_a, dqm_a);
      if (c == 11) sa_a = 20'h55A3C;
      tick();
    end

    // burst 2: address scrambled every cycle after the start edge
    for (int c = 0; c <= 12; c++) begin
      check_cycle("b2", c, 2, 2, 4, 2, 4, 12'h55A, 8'h3C,
                  cmd_a, addr_a, dq_a, oe_a, req_a, ack_a, dqm_a);
      sa_a = 20'($urandom);
      if (c == 10) we_a = 1'b0;
      tick();
    end

    // reset during cycle 5 of a burst
    sa_a = 20'h12345;
    we_a = 1'b1;
    tick();
    for (int c = 0; c <= 5; c++) begin
      check_cycle("rb", c, 2, 2, 4, 2, 8, 12'h123, 8'h45,
                  cmd_a, addr_a, dq_a, oe_a, req_a, ack_a, dqm_a);
      if (c == 5) begin
        rst  = 1'b1;
        we_a = 1'b0;
      end
      tick();
    end
    chk("abort cmd",  32'(cmd_a),  32'h17);
    chk("abort addr", 32'(addr_a), 32'h400);
    chk("abort dq",   32'(dq_a),   32'h0);
    chk("abort oe",   32'(oe_a),   32'h0);
    chk("abort req",  32'(req_a),  32'h0);
    chk("abort ack",  32'(ack_a),  32'h0);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk($sformatf("post-abort %0d ack", c), 32'(ack_a), 32'h0);
      chk($sformatf("post-abort %0d cmd", c), 32'(cmd_a), 32'h17);
    end

    // clean restart after abort; four words were already popped
    sa_a = 20'hFEDCB;
    we_a = 1'b1;
    tick();
    for (int c = 0; c <= 11; c++) begin
      check_cycle("b3", c, 2, 2, 4, 2, 12, 12'hFED, 8'hCB,
                  cmd_a, addr_a, dq_a, oe_a, req_a, ack_a, dqm_a);
      if (c == 10) we_a = 1'b0;
      tick();
    end

    // non-default timing instance
    sa_b = 20'h3C5A7;
    we_b = 1'b1;
    tick();
    for (int c = 0; c <= 16; c++) begin
      check_cycle("p8", c, 3, 3, 8, 1, 0, 12'h3C5, 8'hA7,
                  cmd_b, addr_b, dq_b, oe_b, req_b, ack_b, dqm_b);
      if (c == 15) we_b = 1'b0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_write.md
# sdram_write

Write-burst engine for the SDRAM controller, the write-side counterpart of the read engine under the same arbiter. On a grant from the arbiter it precharges all banks, activates the target row and issues one fixed-length write burst. Burst data is pulled from the write FIFO. It then waits out write recovery and returns a one-cycle acknowledge. Command, address and DQ outputs feed the controller's SDRAM pin mux.

## Interface
Parameters:
- TRP_CYC, 2: cycles from PRECHARGE to ACTIVE (min 1)
- TRCD_CYC, 2: cycles from ACTIVE to WRITE (min 2, required by the FIFO prefetch)
- BURST_LEN, 4: words per burst; must match the SDRAM mode register
- TWR_CYC, 2: NOP cycles after the last data word before ack (min 1)

Ports (one clock; reset is synchronous and active-high):
- S_CLK  in  1  system clock; all logic on its rising edge
- RST  in  1  synchronous active-high reset
- write_en  in  1  arbiter grant; level, held until write_ack is seen
- write_ack  out  1  one-cycle pulse, burst and write recovery complete
- sdram_addr  in  20  {row[11:0], column[7:0]}; captured on the start edge
- fifo_rd_req  out  1  write-FIFO read strobe; FIFO has 1-cycle read latency
- fifo_rd_data  in  16  FIFO output word
- write_addr  out  12  SDRAM A[11:0]
- write_cmd  out  5  {CKE, CS_N, RAS_N, CAS_N, WE_N}
- write_dq  out  16  data to the DQ tri-state
- write_dq_oe  out  1  DQ output enable

## Operation
- Command encodings:
  - NOP = 10111
  - PRECHARGE = 10010
  - ACTIVE = 10011
  - WRITE = 10100
- All outputs are registered.
- Reset values: write_cmd = NOP, write_addr = 12'h400, write_dq = 0, write_dq_oe = 0, fifo_rd_req = 0, write_ack = 0, state = IDLE.
- State machine and transitions:
  - IDLE → PREC when write_en = 1. The same edge latches sdram_addr.
  - PREC → ACT after TRP_CYC cycles.
  - ACT → WR after TRCD_CYC cycles.
  - WR → TWR after BURST_LEN cycles.
  - TWR → DONE after TWR_CYC cycles.
  - DONE → IDLE unconditionally.
- PREC: the first cycle drives PRECHARGE with A10 = 1 (all banks, addr 12'h400). The remaining cycles drive NOP with addr 12'h400.
- ACT: the first cycle drives ACTIVE with addr = row. The remaining cycles drive NOP.
- WR: the first cycle drives WRITE with addr = {4'b0000, column}, so A10 = 0 and there is no auto-precharge. The remaining cycles drive NOP.
  - write_dq_oe = 1 for all BURST_LEN cycles.
  - write_dq carries FIFO words 0 to BURST_LEN-1 in order.
- fifo_rd_req is high for exactly BURST_LEN consecutive cycles. It starts on the first ACT cycle; the engine registers fifo_rd_data two edges after each request.
- TWR: NOP, write_dq_oe = 0.
- DONE: write_ack = 1, NOP. write_en is ignored on the DONE→IDLE edge, so the arbiter has one cycle to drop it.
- sdram_addr changes after the start edge have no effect.
- A write_en rising mid-burst is ignored; a new burst starts only from IDLE.

## Timing
- Cycle 0 is the period after the edge that samples write_en = 1 in IDLE. Values below are for the defaults.
- Cycle 0: PRECHARGE. Cycle 1: NOP.
- Cycle 2: ACTIVE. fifo_rd_req is high in cycles 2–5. Cycle 3: NOP.
- Cycle 4: WRITE + word0. Cycles 5–7: word1–word3.
- Cycles 8–9: NOP, write_dq_oe = 0.
- Cycle 10: write_ack. The earliest next start is the edge after cycle 11.
- General formulas:
  - write_ack appears in cycle TRP_CYC+TRCD_CYC+BURST_LEN+TWR_CYC.
  - Minimum start-to-start spacing is that value + 2.
- RST asserted mid-operation: all outputs return to their reset values on the next edge. No ack is issued and fifo_rd_req drops immediately. FIFO words already popped are discarded; the arbiter must flush or re-issue.
- RST and write_en high on the same edge: reset wins.

## Configuration
- SDRAM_WR_DQM_EN defined:
  - Adds input fifo_rd_mask[1:0] and output write_dqm[1:0].
  - Masks are registered with the same 2-edge alignment as fifo_rd_data, so they are valid with each data word.
  - write_dqm = 2'b00 outside WR; reset value 2'b00.
- SDRAM_WR_DQM_EN undefined: both ports are absent and the top level ties DQM low (all bytes written).

## Structure
- Shared package sdram_pkg holds:
  - the command encodings (CMD_NOP, CMD_PREC, CMD_ACT, CMD_WRITE, CMD_READ);
  - ADDR_PALL = 12'h400;
  - the state encoding type.
- The read engine uses the same package.
- One sub-module, sdram_step_cnt: a loadable down-counter with a terminal-count flag. It sequences the PREC, ACT, WR and TWR phase lengths.

## Test plan
- Single burst, defaults, sdram_addr = 20'hABC12, FIFO words 1111/2222/3333/4444:
  - cmd sequence PREC (c0), ACT addr 12'hABC (c2), WRITE addr 12'h012 (c4);
  - dq = 1111–4444 in c4–c7 with oe = 1;
  - ack only in c10.
- write_en held high through ack: exactly one burst; restart no earlier than the edge after c11.
- RST pulsed in cycle 5: outputs at reset values in cycle 6, fifo_rd_req = 0, no ack, next write_en starts a clean PRECHARGE.
- TRP_CYC = 3, TRCD_CYC = 3, BURST_LEN = 8, TWR_CYC = 1:
  - ACTIVE in c3, WRITE in c6;
  - fifo_rd_req for 8 cycles from c3;
  - ack in c15.
- sdram_addr changed every cycle after start: row and column match the value latched on the start edge.
- SDRAM_WR_DQM_EN defined, masks 00/01/10/11: write_dqm = 00/01/10/11 aligned with words 0–3, and 00 elsewhere.
